// File: rtl/mult_seq_param.sv
// Digit-serial multiplier: retires DIGIT bits of in_b per cycle on operand magnitudes,
// then applies the sign and optional LSB truncation to the registered product.
module mult_seq_param #(
  parameter int BIT_WIDTH = 24,
  parameter int OUT_WIDTH = 48,
  parameter int DIGIT     = 4,
  parameter int TRUNC     = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [BIT_WIDTH-1:0] in_a,
  input  logic [BIT_WIDTH-1:0] in_b,
  input  logic                 in_signed,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OUT_WIDTH-1:0] out,
  output logic                 busy
);

  localparam int N     = BIT_WIDTH / DIGIT;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [OUT_WIDTH-1:0] KEEP_MASK = {OUT_WIDTH{1'b1}} << TRUNC;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t               r_state;
  logic [OUT_WIDTH-1:0] r_magA;
  logic [BIT_WIDTH-1:0] r_magB;
  logic [OUT_WIDTH-1:0] r_acc;
  logic                 r_neg;
  logic [CNT_W-1:0]     r_cnt;

  logic [BIT_WIDTH-1:0] w_absA;
  logic [BIT_WIDTH-1:0] w_absB;
  logic [OUT_WIDTH-1:0] w_partial;
  logic [OUT_WIDTH-1:0] w_accNext;
  logic [OUT_WIDTH-1:0] w_final;
  logic                 w_accept;

  assign w_absA = (in_signed && in_a[BIT_WIDTH-1]) ? -in_a : in_a;
  assign w_absB = (in_signed && in_b[BIT_WIDTH-1]) ? -in_b : in_b;

  // r_magA is pre-shifted each cycle, so this partial already sits at weight DIGIT*cnt
  assign w_partial = r_magA * OUT_WIDTH'(r_magB[DIGIT-1:0]);
  assign w_accNext = r_acc + w_partial;
  assign w_final   = (r_neg ? -w_accNext : w_accNext) & KEEP_MASK;

  assign in_ready = rst_n && ((r_state == IDLE) || ((r_state == DONE) && out_ready));
  assign w_accept = in_valid && in_ready;
  assign busy     = (r_state != IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_magA    <= '0;
      r_magB    <= '0;
      r_acc     <= '0;
      r_neg     <= 1'b0;
      r_cnt     <= '0;
      out       <= '0;
      out_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: ;
        CALC: begin
          r_acc  <= w_accNext;
          r_magA <= r_magA << DIGIT;
          r_magB <= r_magB >> DIGIT;
          r_cnt  <= r_cnt + CNT_W'(1);
          if (r_cnt == CNT_W'(N - 1)) begin
            out       <= w_final;
            out_valid <= 1'b1;
            r_state   <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            r_state   <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase

      // A new accept overrides the DONE->IDLE move, giving DONE->CALC in one edge
      if (w_accept) begin
        r_magA  <= OUT_WIDTH'(w_absA);
        r_magB  <= w_absB;
        r_neg   <= in_signed && (in_a[BIT_WIDTH-1] ^ in_b[BIT_WIDTH-1]);
        r_acc   <= '0;
        r_cnt   <= '0;
        r_state <= CALC;
      end
    end
  end

endmodule

// File: tb/tb_mult_seq_param.sv
// Scoreboard bench for mult_seq_param: default instance plus a TRUNC=8 instance,
// expected products come from a full-width reference multiply.
module tb_mult_seq_param;

  localparam int BW = 24;
  localparam int OW = 48;
  localparam int N  = 6;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid, in_ready, in_signed, out_valid, out_ready, busy;
  logic [BW-1:0] in_a, in_b;
  logic [OW-1:0] out;

  logic          tInValid, tInReady, tInSigned, tOutValid, tOutReady, tBusy;
  logic [BW-1:0] tInA, tInB;
  logic [OW-1:0] tOut;

  int            vectors = 0;
  int            miscompares = 0;
  logic [OW-1:0] sbq[$];
  logic [OW-1:0] held;

  always #5 clk = ~clk;

  mult_seq_param dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_signed(in_signed), .out_valid(out_valid),
    .out_ready(out_ready), .out(out), .busy(busy)
  );

  mult_seq_param #(.TRUNC(8)) dutT (
    .clk(clk), .rst_n(rst_n), .in_valid(tInValid), .in_ready(tInReady),
    .in_a(tInA), .in_b(tInB), .in_signed(tInSigned), .out_valid(tOutValid),
    .out_ready(tOutReady), .out(tOut), .busy(tBusy)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  function automatic logic [OW-1:0] golden(input logic [BW-1:0] a, input logic [BW-1:0] b,
                                           input logic sgn, input int trunc);
    logic signed [OW-1:0] sa, sb;
    logic [OW-1:0] p;
    if (sgn) begin
      sa = {{BW{a[BW-1]}}, a};
      sb = {{BW{b[BW-1]}}, b};
      p  = sa * sb;
    end else begin
      p = {{BW{1'b0}}, a} * {{BW{1'b0}}, b};
    end
    return p & ({OW{1'b1}} << trunc);
  endfunction

  task automatic applyStimulus(input string tag, input logic [BW-1:0] a, input logic [BW-1:0] b,
                               input logic sgn, input logic [OW-1:0] expected);
    in_a = a; in_b = b; in_signed = sgn; in_valid = 1'b1;
    #1;
    for (int i = 0; i < 20 && !in_ready; i++) step();
    check({tag, "_accept"}, 64'(in_ready), 64'(1));
    if (in_ready) sbq.push_back(expected);
    step();
    in_valid = 1'b0;
  endtask

  task automatic checkOutput(input string tag, input bit consume, output logic [OW-1:0] expv);
    for (int i = 0; i < 20 && !out_valid; i++) step();
    check({tag, "_valid"}, 64'(out_valid), 64'(1));
    expv = (sbq.size() > 0) ? sbq.pop_front() : 'x;
    check(tag, 64'(out), 64'(expv));
    if (consume) begin
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
    end
  endtask

  task automatic truncOp(input string tag, input logic [BW-1:0] a, input logic [BW-1:0] b,
                         input logic sgn, input logic [OW-1:0] expected);
    tInA = a; tInB = b; tInSigned = sgn; tInValid = 1'b1;
    #1;
    for (int i = 0; i < 20 && !tInReady; i++) step();
    step();
    tInValid = 1'b0;
    for (int i = 0; i < 20 && !tOutValid; i++) step();
    check({tag, "_valid"}, 64'(tOutValid), 64'(1));
    check(tag, 64'(tOut), 64'(expected));
    step();
  endtask

  task automatic backToBack(input logic sgn, input string tag);
    int got = 0;
    int sent = 0;
    int lastCyc = 0;
    int cyc = 0;
    bit hs, ac;
    logic [OW-1:0] expv;
    in_signed = sgn; in_a = BW'($urandom); in_b = BW'($urandom);
    in_valid = 1'b1; out_ready = 1'b1;
    #1;
    while (got < 100 && cyc < 2000) begin
      hs = out_valid && out_ready;
      ac = in_valid && in_ready;
      if (hs) begin
        expv = (sbq.size() > 0) ? sbq.pop_front() : 'x;
        check(tag, 64'(out), 64'(expv));
        if (got > 0) check({tag, "_interval"}, 64'(cyc - lastCyc), 64'(N + 1));
        lastCyc = cyc;
        got++;
      end
      if (ac) begin
        sbq.push_back(golden(in_a, in_b, sgn, 0));
        sent++;
      end
      step();
      cyc++;
      if (ac) begin
        if (sent < 100) begin
          in_a = BW'($urandom); in_b = BW'($urandom);
        end else begin
          in_valid = 1'b0;
        end
      end
    end
    check({tag, "_count"}, 64'(got), 64'(100));
    in_valid = 1'b0; out_ready = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_signed = 1'b0; in_a = '0; in_b = '0;
    tInValid = 1'b0; tOutReady = 1'b1; tInSigned = 1'b0; tInA = '0; tInB = '0;
    step();
    step();
    check("rst_out", 64'(out), 64'(0));
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_in_ready", 64'(in_ready), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    rst_n = 1'b1;
    #1;
    check("idle_in_ready", 64'(in_ready), 64'(1));

    // Unsigned max with exact latency and busy throughout
    applyStimulus("umax", 24'hFFFFFF, 24'hFFFFFF, 1'b0, 48'hFFFFFE000001);
    for (int k = 0; k < N; k++) begin
      check("umax_busy", 64'(busy), 64'(1));
      check("umax_early_valid", 64'(out_valid), 64'(0));
      step();
    end
    check("umax_latency", 64'(out_valid), 64'(1));
    checkOutput("umax", 1'b1, held);
    check("umax_idle_valid", 64'(out_valid), 64'(0));
    check("umax_idle_busy", 64'(busy), 64'(0));
    check("umax_out_hold", 64'(out), 64'(48'hFFFFFE000001));

    applyStimulus("s_m1x3", 24'hFFFFFF, 24'h000003, 1'b1, 48'hFFFFFFFFFFFD);
    checkOutput("s_m1x3", 1'b1, held);
    applyStimulus("s_minxmin", 24'h800000, 24'h800000, 1'b1, 48'h400000000000);
    checkOutput("s_minxmin", 1'b1, held);
    applyStimulus("s_minx1", 24'h800000, 24'h000001, 1'b1, 48'hFFFFFF800000);
    checkOutput("s_minx1", 1'b1, held);

    // Backpressure: result held while in_valid toggles operands
    applyStimulus("bp", 24'h123456, 24'h00ABCD, 1'b0, golden(24'h123456, 24'h00ABCD, 1'b0, 0));
    checkOutput("bp", 1'b0, held);
    in_valid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      in_a = BW'($urandom); in_b = BW'($urandom); in_signed = 1'($urandom);
      #1;
      check("bp_out_stable", 64'(out), 64'(held));
      check("bp_in_ready", 64'(in_ready), 64'(0));
      check("bp_out_valid", 64'(out_valid), 64'(1));
      step();
    end
    in_a = 24'h000321; in_b = 24'h000007; in_signed = 1'b0; out_ready = 1'b1;
    #1;
    check("bp_same_edge_ready", 64'(in_ready), 64'(1));
    if (in_ready) sbq.push_back(golden(24'h000321, 24'h000007, 1'b0, 0));
    step();
    in_valid = 1'b0; out_ready = 1'b0;
    check("bp_new_busy", 64'(busy), 64'(1));
    check("bp_new_valid", 64'(out_valid), 64'(0));
    checkOutput("bp_next", 1'b1, held);

    backToBack(1'b0, "b2b_u");
    backToBack(1'b1, "b2b_s");

    // Reset in the middle of CALC
    applyStimulus("mid", 24'hABCDEF, 24'h123456, 1'b0, golden(24'hABCDEF, 24'h123456, 1'b0, 0));
    step(); step(); step();
    rst_n = 1'b0;
    #1;
    check("mid_rst_in_ready", 64'(in_ready), 64'(0));
    step();
    check("mid_rst_out", 64'(out), 64'(0));
    check("mid_rst_out_valid", 64'(out_valid), 64'(0));
    check("mid_rst_in_ready2", 64'(in_ready), 64'(0));
    check("mid_rst_busy", 64'(busy), 64'(0));
    rst_n = 1'b1;
    sbq.delete();
    applyStimulus("post_rst", 24'd1000, 24'd1000, 1'b0, 48'h0000000F4240);
    checkOutput("post_rst", 1'b1, held);

    truncOp("trunc_u", 24'd1000, 24'd1000, 1'b0, 48'h0000000F4200);
    truncOp("trunc_s", 24'hFFFC18, 24'd1000, 1'b1, 48'hFFFFFFF0BD00);

    check("sb_empty", 64'(sbq.size()), 64'(0));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
